// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared widths, sequencer state encoding and the buffered operand-pair layout
package mac_seq_pkg;
  localparam int OPW  = 8;
  localparam int ACCW = 16;
  localparam int LENW = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT1, WAIT2, HOLD} state_e;
  typedef struct packed {
    logic           last;
    logic [OPW-1:0] x;
    logic [OPW-1:0] y;
  } pair_t;
endpackage

// File: rtl/mac_operand_sequencer_if.sv
// mac_operand_sequencer_if: operand stream in, fmac drive/return, result stream out
//   master: operand source / result sink / fmac side
//   slave : the sequencer
interface mac_operand_sequencer_if;
  import mac_seq_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_x;
  logic [OPW-1:0]  in_y;
  logic            in_last;
  logic            mac_rst_n;
  logic [OPW-1:0]  x;
  logic [OPW-1:0]  y;
  logic [ACCW-1:0] a;
  logic            res_valid;
  logic            res_ready;
  logic [ACCW-1:0] res_data;
  logic [LENW-1:0] res_len;
  logic            err_len;
  modport master (
    output in_valid, in_x, in_y, in_last, a, res_ready,
    input  in_ready, mac_rst_n, x, y, res_valid, res_data, res_len, err_len
  );
  modport slave (
    input  in_valid, in_x, in_y, in_last, a, res_ready,
    output in_ready, mac_rst_n, x, y, res_valid, res_data, res_len, err_len
  );
endinterface

// File: rtl/mac_operand_sequencer_fifo.sv
// operand_fifo: synchronous FIFO for operand pairs
//   clk, rst_n (async active-low), push/wdata, pop/rdata, full, empty
//   Push is ignored when full (even with a same-cycle pop); pop is ignored when empty.
module operand_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic         do_push, do_pop;
  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_comb begin
    empty   = wp_q == rp_q;
    full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wp_d    = wp_q + {{AW{1'b0}}, do_push};
    rp_d    = rp_q + {{AW{1'b0}}, do_pop};
    rdata   = mem_q[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: buffers operand pairs, streams them into fmac and returns the dot product
//   clk, rst_n (async active-low)
//   bus.in_*  : operand pair stream (valid/ready, last marks end of vector)
//   bus.x/y   : registered fmac operands; bus.mac_rst_n clears fmac; bus.a is its accumulator
//   bus.res_* : captured dot product and vector length (valid/ready); bus.err_len sticky overflow
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LEN    = 255
) (
  input logic clk,
  input logic rst_n,
  mac_operand_sequencer_if.slave bus
);
  localparam logic [9:0] MAX_L = 10'(MAX_LEN);
  state_e          state_q, state_d;
  logic [OPW-1:0]  x_q, x_d, y_q, y_d;
  logic [8:0]      len_q, len_d;
  logic [ACCW-1:0] res_data_q, res_data_d;
  logic [LENW-1:0] res_len_q, res_len_d;
  logic            res_valid_q, res_valid_d, err_q, err_d;
  logic            full, empty, pop;
  pair_t           wr, rd;
  assign wr = '{last: bus.in_last, x: bus.in_x, y: bus.in_y};
  operand_fifo #(.W($bits(pair_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .wdata (wr),
    .pop   (pop),
    .rdata (rd),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    state_d     = state_q;
    x_d         = '0;
    y_d         = '0;
    len_d       = len_q;
    res_data_d  = res_data_q;
    res_len_d   = res_len_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    pop         = 1'b0;
    case (state_q)
      IDLE:   state_d = empty ? IDLE : CLEAR;
      CLEAR:  state_d = STREAM;
      STREAM:
        if (!empty) begin
          pop     = 1'b1;
          x_d     = rd.x;
          y_d     = rd.y;
          len_d   = len_q[8] ? len_q : len_q + 9'd1;
          err_d   = err_q || ({1'b0, len_q} + 10'd1 > MAX_L);
          state_d = rd.last ? WAIT1 : STREAM;
        end
      WAIT1:  state_d = WAIT2;
      // fmac has absorbed the last pair by this edge, so a is the final dot product.
      WAIT2: begin
        res_data_d  = bus.a;
        res_len_d   = len_q[8] ? 8'hFF : len_q[7:0];
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD:
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          len_d       = '0;
          state_d     = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      len_q       <= '0;
      res_data_q  <= '0;
      res_len_q   <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      len_q       <= len_d;
      res_data_q  <= res_data_d;
      res_len_q   <= res_len_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  // Decoded from registered state only; rst_n folds in so fmac clears during reset too.
  assign bus.mac_rst_n = rst_n && (state_q != CLEAR);
  assign bus.in_ready  = !full;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_len   = res_len_q;
  assign bus.err_len   = err_q;
endmodule
